exe_muldiv: RTL and testbench
=============================

Name: exe_muldiv

Overview:
- Iterative multiply/divide unit in the EXE stage, directly downstream of the ID/EXE pipeline register.
- Consumes the latched A/B operands and a decoded op, and owns the architectural HI/LO registers.
- Asserts a combinational stall that drives the pipeline `go` enables low (PC, IF/ID, ID/EXE) while an operation is in flight.
- Services MULT, MULTU, DIV, DIVU, MTHI, MTLO; MFHI/MFLO read `hi`/`lo` directly.

Parameters:
- WIDTH, 32, operand width; RUN phase lasts exactly WIDTH cycles.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  EXE holds a mul/div instruction (decoded from ID/EXE instruction_out).
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start.
- a  in  WIDTH  rs operand (multiplicand/dividend), from A_out after forwarding.
- b  in  WIDTH  rt operand (multiplier/divisor), from B_out after forwarding.
- hi_we  in  1  MTHI write enable.
- lo_we  in  1  MTLO write enable.
- wdata  in  WIDTH  MTHI/MTLO data (rs).
- flush  in  1  abort in-flight operation (exception/redirect clear).
- hi  out  WIDTH  architectural HI.
- lo  out  WIDTH  architectural LO.
- stall  out  1  combinational; high means freeze PC, IF/ID, ID/EXE.
- done  out  1  one-cycle pulse in the FIX cycle (HI/LO written at the end of that cycle).

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous and active-high.
- Reset: state=IDLE, hi=0, lo=0, done=0, internal accumulators/counter=0. Reset mid-operation aborts immediately with no HI/LO update.
- States: IDLE, RUN, FIX.
- IDLE -> RUN on start & ~flush:
  - Latch |a|, |b| and the sign flags (signs only for op 01 and 11; treated as unsigned otherwise).
  - Latch op; counter=0.
- RUN:
  - One iteration per cycle; counter increments.
  - After WIDTH iterations (counter==WIDTH-1 at the edge) -> FIX.
- FIX:
  - done=1; sign correction applied; hi/lo written at the clock edge; -> IDLE.
- stall = (state==IDLE & start & ~flush) | (state==RUN). stall=0 in FIX so the instruction leaves EXE on the same edge HI/LO update.
- Total EXE occupancy: WIDTH+2 cycles; stall high for WIDTH+1 consecutive cycles.
- start is ignored in FIX and RUN (same instruction still present); no retrigger.
- Multiply: shift-add over 2*WIDTH-bit product of magnitudes. Result {hi,lo}; negated (two's complement, 2*WIDTH bits) if signed and sign(a)!=sign(b).
- Divide: restoring, one quotient bit per cycle on magnitudes. lo=quotient, negated if signed and signs differ; hi=remainder, negated if signed and a negative.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (falls out naturally; no trap).
- Divide by zero: still runs the full WIDTH+2 cycles; result lo=all-ones, hi=a (original operand, unsigned/signed alike).
- MTHI/MTLO:
  - Applied at the edge only when state==IDLE and ~start; hi_we writes hi, lo_we writes lo, both may be set together.
  - Ignored in RUN/FIX; the pipeline is stalled, so no legal write arrives there.
- flush:
  - Highest priority after rst; any state -> IDLE next edge.
  - hi/lo unchanged; done not asserted; stall low in the flush cycle.
- Reads of hi/lo are combinational register outputs; no bypass of the in-flight result.

Test Plan:
- rst pulse mid-RUN -> hi=lo=0, stall=0, state IDLE asynchronously.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> stall high 33 cycles, done in cycle 34, hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3), b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678 after full latency; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Preload hi/lo via MTHI 0xAAAA0000 / MTLO 0x5555; start DIVU 100/7, assert flush on RUN cycle 10 -> stall drops, hi=0xAAAA0000, lo=0x5555, no done.
- Back-to-back: DIVU 100/7 then MULTU 3*4 on the next EXE instruction -> hi=2, lo=14 after the first, then hi=0, lo=12; no cycle gap beyond the defined stall.

Source files
------------

// File: rtl/exe_muldiv.sv
// exe_muldiv: iterative multiply/divide unit for the EXE stage.
// Owns the architectural HI/LO registers and stalls the upstream pipeline
// while an operation is in flight.
//
// Ports:
//   clk    pipeline clock (rising edge)
//   rst    asynchronous active-high reset
//   start  EXE holds a mul/div instruction
//   op     00 MULTU, 01 MULT, 10 DIVU, 11 DIV (sampled with start)
//   a, b   rs/rt operands
//   hi_we  MTHI write enable
//   lo_we  MTLO write enable
//   wdata  MTHI/MTLO data
//   flush  abort any in-flight operation
//   hi, lo architectural HI/LO
//   stall  combinational freeze request for PC, IF/ID, ID/EXE
//   done   one-cycle pulse in the cycle HI/LO are written
module exe_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             stall,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;     // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   opnd_q, opnd_d;   // mult: |a| multiplicand; div: |b| divisor
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               div_q, div_d;
  logic               neg_q, neg_d;     // operand signs differ (signed ops only)
  logic               nega_q, nega_d;   // dividend negative (signed ops only)
  logic               bz_q, bz_d;       // divisor was zero

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic s);
    return s ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic s);
    return s ? -v : v;
  endfunction

  logic               sa, sb;
  logic [WIDTH:0]     msum;
  logic [WIDTH:0]     rsh, diff;
  logic [2*WIDTH-1:0] prod;

  assign sa = op[0] & a[WIDTH-1];
  assign sb = op[0] & b[WIDTH-1];

  // Shift-add: add multiplicand when the current multiplier bit is set, then shift right.
  assign msum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});

  // Restoring step: bring down the next dividend bit and trial-subtract the divisor.
  // The remainder stays below the divisor, so a clear borrow bit means the result fits.
  assign rsh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign diff = rsh - {1'b0, opnd_q};

  assign prod = cond_neg2(acc_q, neg_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div_d   = div_q;
    neg_d   = neg_q;
    nega_d  = nega_q;
    bz_d    = bz_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = RUN;
            cnt_d   = '0;
            div_d   = op[1];
            neg_d   = sa ^ sb;
            nega_d  = sa;
            bz_d    = (b == '0);
            if (op[1]) begin
              opnd_d = cond_neg(b, sb);
              acc_d  = {{WIDTH{1'b0}}, cond_neg(a, sa)};
            end else begin
              opnd_d = cond_neg(a, sa);
              acc_d  = {{WIDTH{1'b0}}, cond_neg(b, sb)};
            end
          end else begin
            if (hi_we) hi_d = wdata;
            if (lo_we) lo_d = wdata;
          end
        end
        RUN: begin
          cnt_d = cnt_q + CW'(1);
          if (div_q) begin
            if (!diff[WIDTH]) acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else              acc_d = {rsh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end else begin
            acc_d = {msum, acc_q[WIDTH-1:1]};
          end
          if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
        end
        FIX: begin
          state_d = IDLE;
          if (div_q) begin
            // Divide by zero leaves |a| as remainder, so sign-correcting it restores a.
            lo_d = bz_q ? {WIDTH{1'b1}} : cond_neg(acc_q[WIDTH-1:0], neg_q);
            hi_d = cond_neg(acc_q[2*WIDTH-1:WIDTH], nega_q);
          end else begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      nega_q  <= 1'b0;
      bz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      nega_q  <= nega_d;
      bz_q    <= bz_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  // Low in FIX so the instruction leaves EXE on the same edge HI/LO update.
  assign stall = ~flush & (((state_q == IDLE) & start) | (state_q == RUN));
  assign done  = ~flush & (state_q == FIX);

endmodule

// File: tb/tb_exe_muldiv.sv
// Directed testbench for exe_muldiv.
module tb_exe_muldiv;

  logic        clk, rst, start, hi_we, lo_we, flush;
  logic [1:0]  op;
  logic [31:0] a, b, wdata, hi, lo;
  logic        stall, done;

  int nassert = 0;
  int nfail   = 0;

  exe_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .flush(flush),
    .hi(hi), .lo(lo), .stall(stall), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; applies the write across the next rising edge.
  task automatic mt(input logic h, input logic l, input logic [31:0] d);
    hi_we = h; lo_we = l; wdata = d;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
  endtask

  // Called just after a negedge; returns just after the negedge following the FIX edge
  // with start still high so a following op can be issued with no gap.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
    int  cyc;
    int  stalls;
    bit  seen;
    start = 1'b1; op = o; a = x; b = y;
    #1;
    cyc = 1; stalls = 0; seen = 1'b0;
    while (!seen && cyc <= 100) begin
      if (stall) stalls++;
      if (done) seen = 1'b1;
      else begin
        @(negedge clk); #1;
        cyc++;
      end
    end
    chk({tag, "_done_cycle"}, cyc, 34);
    chk({tag, "_stall_cycles"}, stalls, 33);
    @(negedge clk);
    chk({tag, "_hi"}, hi, eh);
    chk({tag, "_lo"}, lo, el);
  endtask

  initial begin
    bit seen_done;
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;

    // Preload then reset in the middle of RUN.
    mt(1'b1, 1'b0, 32'h11);
    mt(1'b0, 1'b1, 32'h22);
    chk("mt_hi", hi, 32'h11);
    chk("mt_lo", lo, 32'h22);
    start = 1'b1; op = 2'b00; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    repeat (6) @(negedge clk);
    #1;
    chk("midrun_stall", stall, 1);
    #2;
    rst = 1'b1; start = 1'b0;
    #1;
    chk("async_rst_hi", hi, 0);
    chk("async_rst_lo", lo, 0);
    chk("async_rst_stall", stall, 0);
    chk("async_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_stall", stall, 0);

    @(negedge clk);
    run_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    start = 1'b0; @(negedge clk);
    run_op("mult_neg", 2'b01, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    start = 1'b0; @(negedge clk);
    run_op("div_neg", 2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    start = 1'b0; @(negedge clk);
    run_op("divu_zero", 2'b10, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF);
    start = 1'b0; @(negedge clk);
    run_op("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    start = 1'b0; @(negedge clk);

    // Flush in RUN cycle 10 keeps the preloaded HI/LO.
    mt(1'b1, 1'b0, 32'hAAAA0000);
    mt(1'b0, 1'b1, 32'h00005555);
    start = 1'b1; op = 2'b10; a = 32'd100; b = 32'd7;
    repeat (10) @(negedge clk);
    #1;
    chk("flush_pre_stall", stall, 1);
    flush = 1'b1;
    #1;
    chk("flush_stall", stall, 0);
    chk("flush_done", done, 0);
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    #1;
    chk("flush_after_stall", stall, 0);
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (done || stall) seen_done = 1'b1;
    end
    chk("flush_no_done", seen_done, 0);
    chk("flush_hi", hi, 32'hAAAA0000);
    chk("flush_lo", lo, 32'h00005555);

    // Back-to-back: second op enters EXE in the cycle right after FIX.
    @(negedge clk);
    run_op("b2b_divu", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("b2b_multu", 2'b00, 32'd3, 32'd4, 32'd0, 32'd12);
    start = 1'b0;
    #1;
    chk("final_stall", stall, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
